multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter-free interface; ports listed below (clock and reset first).
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 op  input  6  instruction opcode from data_path instruction register.
REQ-005 Funct  input  6  R-type function field from data_path.
REQ-006 zero  input  1  ALU zero flag from data_path (combinational, same cycle).
REQ-007 ALUSrcA  output  1  0=PC, 1=register A.
REQ-008 ALUSrcB  output  2  00=register B, 01=constant 4, 10=SignImm, 11=SignImm<<2.
REQ-009 ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 100 slt.
REQ-010 PC_enable  output  1  PC register write enable (PCEn).
REQ-011 IorD  output  1  1=PC addresses memory (instruction), 0=ALUOut (data).
REQ-012 MemWrite, IRWrite, RegWrite  output  1 each  memory, instruction register, register file write enables.
REQ-013 RegDst  output  1  1=rd, 0=rt destination; MemtoReg  output  1  1=ALUOut, 0=memory data.
REQ-014 PCSrc  output  1  0=ALU result (PC+4), 1=ALUOut (branch target).
REQ-015 illegal_op  output  1  one-cycle pulse on unsupported opcode/funct; state_disp  output  4  current state code.

Function
REQ-016 Moore FSM; all outputs except PC_enable decoded from state register only; PC_enable = PCWrite | (Branch & zero).
REQ-017 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, ADDIEXEC, ADDIWB, BRANCH.
REQ-018 FETCH: IorD=1, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUControl=000, PCSrc=0, PC_enable=1; -> DECODE.
REQ-019 DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=000 (branch target to ALUOut); next by op.
REQ-020 op 000000 -> EXECUTE (ALUSrcA=1, ALUSrcB=00, ALUControl per Funct) -> ALUWB (RegWrite=1, RegDst=1, MemtoReg=1) -> FETCH.
REQ-021 Funct map: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; other Funct: ALUControl=000, illegal_op pulse in EXECUTE, ALUWB skipped (-> FETCH).
REQ-022 op 100011 (lw) / 101011 (sw) -> MEMADR (ALUSrcA=1, ALUSrcB=10, add); lw -> MEMRD (IorD=0) -> MEMWB (RegWrite=1, RegDst=0, MemtoReg=0) -> FETCH; sw -> MEMWR (IorD=0, MemWrite=1) -> FETCH.
REQ-023 op 001000 (addi) -> ADDIEXEC (ALUSrcA=1, ALUSrcB=10, add) -> ADDIWB (RegWrite=1, RegDst=0, MemtoReg=1) -> FETCH.
REQ-024 op 000100 (beq) -> BRANCH (ALUSrcA=1, ALUSrcB=00, sub, PCSrc=1, Branch=1) -> FETCH; PC_enable=zero in that cycle.
REQ-025 Any other op in DECODE: illegal_op=1 for that cycle, -> FETCH, no write enable asserted.
REQ-026 Cycle counts: R-type 4, lw 5, sw 4, addi 4, beq 3; no stalls or handshakes.
REQ-027 Non-listed outputs in each state SHALL be 0 (no X driven).

Reset
REQ-028 reset low SHALL immediately force state=FETCH and, while low, force PC_enable, IRWrite, MemWrite, RegWrite, illegal_op to 0.
REQ-029 Reset asserted mid-instruction SHALL abort it; no partial write after release; first edge after release executes FETCH.

Configuration
REQ-030 Macro BNE_EN defined: op 000101 (bne) -> BRANCH with PC_enable = ~zero; cycle count 3.
REQ-031 BNE_EN undefined: op 000101 treated as illegal per REQ-025.

Structure
REQ-032 Shared package/header: state codes, opcode and Funct constants, ALUControl codes, ALUOp codes.
REQ-033 One sub-module alu_decoder (2-bit ALUOp + Funct -> ALUControl, illegal flag), combinational.

Verification
REQ-034 reset low 2 cycles then high -> state_disp=FETCH, IRWrite=1, PC_enable=1, IorD=1 on first cycle; enables 0 during reset.
REQ-035 op=000000, Funct=100010 -> FETCH, DECODE, EXECUTE (ALUControl=001, ALUSrcB=00), ALUWB (RegWrite=1, RegDst=1, MemtoReg=1), FETCH.
REQ-036 op=100011 -> 5 states, MEMRD IorD=0, MEMWB RegWrite=1, MemtoReg=0; op=101011 -> MEMWR MemWrite=1, 4 states.
REQ-037 op=000100, zero=1 in BRANCH -> PC_enable=1, PCSrc=1; zero=0 -> PC_enable=0; back to FETCH either way.
REQ-038 op=111111 -> illegal_op=1 one cycle in DECODE, no enables, FETCH next; op=000101 same without BNE_EN, branch on zero=0 with it.
REQ-039 reset pulled low during MEMWR -> MemWrite drops immediately, FETCH after release.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS controller: state codes, opcode/funct
// constants, ALU control and ALUOp codes, and the internal control-word type.
package multicycle_control_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned ALUC_W  = 3;
    localparam int unsigned ALUOP_W = 2;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned SRCB_W  = 2;

    typedef enum logic [STATE_W-1:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        ADDIEXEC = 4'd8,
        ADDIWB   = 4'd9,
        BRANCH   = 4'd10
    } state_e;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;

    localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

    localparam logic [ALUC_W-1:0] ALUC_ADD = 3'b000;
    localparam logic [ALUC_W-1:0] ALUC_SUB = 3'b001;
    localparam logic [ALUC_W-1:0] ALUC_AND = 3'b010;
    localparam logic [ALUC_W-1:0] ALUC_OR  = 3'b011;
    localparam logic [ALUC_W-1:0] ALUC_SLT = 3'b100;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [SRCB_W-1:0] SRCB_REG    = 2'b00;
    localparam logic [SRCB_W-1:0] SRCB_FOUR   = 2'b01;
    localparam logic [SRCB_W-1:0] SRCB_IMM    = 2'b10;
    localparam logic [SRCB_W-1:0] SRCB_IMM_SH = 2'b11;

    // Per-state control word before reset gating and branch resolution.
    typedef struct packed {
        logic              alu_src_a;
        logic [SRCB_W-1:0] alu_src_b;
        logic              iord;
        logic              ir_write;
        logic              mem_write;
        logic              reg_write;
        logic              reg_dst;
        logic              mem_to_reg;
        logic              pc_src;
        logic              pc_write;
        logic              branch;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath signal bundle. The datapath side (master) supplies the
// decoded instruction fields and zero flag; the controller (slave) drives the controls.
interface multicycle_control_if;
    import multicycle_control_pkg::*;

    logic [OP_W-1:0]    op;
    logic [FUNCT_W-1:0] Funct;
    logic               zero;

    logic               ALUSrcA;
    logic [SRCB_W-1:0]  ALUSrcB;
    logic [ALUC_W-1:0]  ALUControl;
    logic               PC_enable;
    logic               IorD;
    logic               MemWrite;
    logic               IRWrite;
    logic               RegWrite;
    logic               RegDst;
    logic               MemtoReg;
    logic               PCSrc;
    logic               illegal_op;
    logic [STATE_W-1:0] state_disp;

    modport master (
        output op, Funct, zero,
        input  ALUSrcA, ALUSrcB, ALUControl, PC_enable, IorD, MemWrite, IRWrite,
               RegWrite, RegDst, MemtoReg, PCSrc, illegal_op, state_disp
    );

    modport slave (
        input  op, Funct, zero,
        output ALUSrcA, ALUSrcB, ALUControl, PC_enable, IorD, MemWrite, IRWrite,
               RegWrite, RegDst, MemtoReg, PCSrc, illegal_op, state_disp
    );

endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// ALU decoder: maps ALUOp plus the R-type funct field to an ALUControl code and
// flags funct values the datapath does not implement.
module alu_decoder
    import multicycle_control_pkg::*;
(
    input  logic [ALUOP_W-1:0] alu_op,
    input  logic [FUNCT_W-1:0] funct,
    output logic [ALUC_W-1:0]  alu_control_c,
    output logic               illegal_c
);

    always_comb begin
        alu_control_c = ALUC_ADD;
        illegal_c     = 1'b0;
        case (alu_op)
            ALUOP_SUB:   alu_control_c = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_control_c = ALUC_ADD;
                    FUNCT_SUB: alu_control_c = ALUC_SUB;
                    FUNCT_AND: alu_control_c = ALUC_AND;
                    FUNCT_OR:  alu_control_c = ALUC_OR;
                    FUNCT_SLT: alu_control_c = ALUC_SLT;
                    default:   illegal_c     = 1'b1;
                endcase
            end
            default: alu_control_c = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore-style controller for a multicycle MIPS subset (R-type, lw, sw, addi, beq).
// Define BNE_EN to also accept bne, which shares the BRANCH state with inverted zero.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.slave  bus
);

    state_e              state_q;
    state_e              state_d;
    ctrl_t               ctrl_c;
    logic                illegal_c;
    logic [ALUOP_W-1:0]  alu_op_c;
    logic [ALUC_W-1:0]   alu_control_c;
    logic                dec_illegal_c;
    logic                branch_cond_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    // ALUOp depends on state only, kept apart from the main decode to avoid a
    // false combinational loop through the ALU decoder.
    always_comb begin
        alu_op_c = ALUOP_ADD;
        case (state_q)
            EXECUTE: alu_op_c = ALUOP_FUNCT;
            BRANCH:  alu_op_c = ALUOP_SUB;
            default: alu_op_c = ALUOP_ADD;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op        (alu_op_c),
        .funct         (bus.Funct),
        .alu_control_c (alu_control_c),
        .illegal_c     (dec_illegal_c)
    );

    always_comb begin
        state_d   = state_q;
        ctrl_c    = '0;
        illegal_c = 1'b0;
        case (state_q)
            FETCH: begin
                ctrl_c.iord      = 1'b1;
                ctrl_c.ir_write  = 1'b1;
                ctrl_c.alu_src_b = SRCB_FOUR;
                ctrl_c.pc_write  = 1'b1;
                state_d          = DECODE;
            end
            DECODE: begin
                ctrl_c.alu_src_b = SRCB_IMM_SH;
                case (bus.op)
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_ADDI:      state_d = ADDIEXEC;
                    OP_BEQ:       state_d = BRANCH;
`ifdef BNE_EN
                    OP_BNE:       state_d = BRANCH;
`endif
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_IMM;
                state_d          = (bus.op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: state_d = MEMWB;
            MEMWB: begin
                ctrl_c.reg_write = 1'b1;
                state_d          = FETCH;
            end
            MEMWR: begin
                ctrl_c.mem_write = 1'b1;
                state_d          = FETCH;
            end
            EXECUTE: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_REG;
                illegal_c        = dec_illegal_c;
                state_d          = dec_illegal_c ? FETCH : ALUWB;
            end
            ALUWB: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.reg_dst    = 1'b1;
                ctrl_c.mem_to_reg = 1'b1;
                state_d           = FETCH;
            end
            ADDIEXEC: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_IMM;
                state_d          = ADDIWB;
            end
            ADDIWB: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.mem_to_reg = 1'b1;
                state_d           = FETCH;
            end
            BRANCH: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_REG;
                ctrl_c.pc_src    = 1'b1;
                ctrl_c.branch    = 1'b1;
                state_d          = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // The instruction register holds op stable through BRANCH, so op selects beq/bne.
`ifdef BNE_EN
    assign branch_cond_c = (bus.op == OP_BNE) ? ~bus.zero : bus.zero;
`else
    assign branch_cond_c = bus.zero;
`endif

    assign bus.ALUSrcA    = ctrl_c.alu_src_a;
    assign bus.ALUSrcB    = ctrl_c.alu_src_b;
    assign bus.ALUControl = alu_control_c;
    assign bus.IorD       = ctrl_c.iord;
    assign bus.RegDst     = ctrl_c.reg_dst;
    assign bus.MemtoReg   = ctrl_c.mem_to_reg;
    assign bus.PCSrc      = ctrl_c.pc_src;
    assign bus.state_disp = state_q;

    // Write enables and illegal_op are held low for as long as reset is asserted.
    assign bus.PC_enable  = reset & (ctrl_c.pc_write | (ctrl_c.branch & branch_cond_c));
    assign bus.IRWrite    = reset & ctrl_c.ir_write;
    assign bus.MemWrite   = reset & ctrl_c.mem_write;
    assign bus.RegWrite   = reset & ctrl_c.reg_write;
    assign bus.illegal_op = reset & illegal_c;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed instructions queue per-cycle
// expected control words; a negedge monitor pops and compares them.
module tb_multicycle_control;

    localparam logic [3:0] ST_F    = 4'd0;
    localparam logic [3:0] ST_D    = 4'd1;
    localparam logic [3:0] ST_MA   = 4'd2;
    localparam logic [3:0] ST_MR   = 4'd3;
    localparam logic [3:0] ST_MWB  = 4'd4;
    localparam logic [3:0] ST_MWR  = 4'd5;
    localparam logic [3:0] ST_EX   = 4'd6;
    localparam logic [3:0] ST_AWB  = 4'd7;
    localparam logic [3:0] ST_AE   = 4'd8;
    localparam logic [3:0] ST_AIWB = 4'd9;
    localparam logic [3:0] ST_BR   = 4'd10;

    typedef struct packed {
        logic [3:0] st;
        logic       a;
        logic [1:0] b;
        logic [2:0] aluc;
        logic       pcen;
        logic       iord;
        logic       mw;
        logic       irw;
        logic       rw;
        logic       rd;
        logic       m2r;
        logic       pcsrc;
        logic       ill;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t  exp_q[$];
    string name_q[$];

    multicycle_control_if bus();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Hand-written expected control word for each state; caller supplies ALUControl,
    // PC_enable and illegal_op for the instruction at hand.
    function automatic exp_t e(input logic [3:0] s, input logic [2:0] aluc,
                               input logic pcen, input logic ill);
        exp_t x;
        x      = '0;
        x.st   = s;
        x.aluc = aluc;
        x.pcen = pcen;
        x.ill  = ill;
        case (s)
            ST_F:        begin x.iord = 1'b1; x.irw = 1'b1; x.b = 2'b01; end
            ST_D:        x.b = 2'b11;
            ST_MA, ST_AE: begin x.a = 1'b1; x.b = 2'b10; end
            ST_MWB:      x.rw = 1'b1;
            ST_MWR:      x.mw = 1'b1;
            ST_EX:       x.a = 1'b1;
            ST_AWB:      begin x.rw = 1'b1; x.rd = 1'b1; x.m2r = 1'b1; end
            ST_AIWB:     begin x.rw = 1'b1; x.m2r = 1'b1; end
            ST_BR:       begin x.a = 1'b1; x.pcsrc = 1'b1; end
            default:     ;
        endcase
        return x;
    endfunction

    // While reset is low: FETCH decode visible, every enable forced off.
    function automatic exp_t e_rst();
        exp_t x;
        x      = e(ST_F, 3'b000, 1'b0, 1'b0);
        x.irw  = 1'b0;
        return x;
    endfunction

    function automatic exp_t sample();
        exp_t g;
        g.st    = bus.state_disp;
        g.a     = bus.ALUSrcA;
        g.b     = bus.ALUSrcB;
        g.aluc  = bus.ALUControl;
        g.pcen  = bus.PC_enable;
        g.iord  = bus.IorD;
        g.mw    = bus.MemWrite;
        g.irw   = bus.IRWrite;
        g.rw    = bus.RegWrite;
        g.rd    = bus.RegDst;
        g.m2r   = bus.MemtoReg;
        g.pcsrc = bus.PCSrc;
        g.ill   = bus.illegal_op;
        return g;
    endfunction

    task automatic check(input string nm, input exp_t x);
        exp_t g;
        g = sample();
        checks++;
        if (g !== x) begin
            errors++;
            $display("FAIL %s: got %h expected %h (state got %0d expected %0d)",
                     nm, g, x, g.st, x.st);
        end
    endtask

    always @(negedge clk) begin
        exp_t  x;
        string nm;
        if (exp_q.size() != 0) begin
            x  = exp_q.pop_front();
            nm = name_q.pop_front();
            check(nm, x);
        end
    end

    task automatic push(input string nm, input exp_t x);
        exp_q.push_back(x);
        name_q.push_back(nm);
    endtask

    task automatic set_in(input logic [5:0] o, input logic [5:0] f, input logic z);
        bus.op    = o;
        bus.Funct = f;
        bus.zero  = z;
    endtask

    task automatic fd(input string nm);
        push({nm, " FETCH"},  e(ST_F, 3'b000, 1'b1, 1'b0));
        push({nm, " DECODE"}, e(ST_D, 3'b000, 1'b0, 1'b0));
    endtask

    // Wait for the monitor to consume all expectations; optionally step into the next FETCH.
    task automatic drain(input bit advance);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain timeout: %0d expectations left, required 0", exp_q.size());
            exp_q.delete();
            name_q.delete();
        end
        if (advance) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [5:0] f_tab [4] = '{6'b100000, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] c_tab [4] = '{3'b000,    3'b010,    3'b011,    3'b100};

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        set_in(6'b000000, 6'b000000, 1'b0);
        push("reset cycle0", e_rst());
        push("reset cycle1", e_rst());
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        set_in(6'b000000, 6'b100010, 1'b0);
        fd("rsub");
        push("rsub EXECUTE", e(ST_EX,  3'b001, 1'b0, 1'b0));
        push("rsub ALUWB",   e(ST_AWB, 3'b000, 1'b0, 1'b0));
        drain(1'b1);

        for (int i = 0; i < 4; i++) begin
            set_in(6'b000000, f_tab[i], 1'b1);
            fd("rtype");
            push("rtype EXECUTE", e(ST_EX,  c_tab[i], 1'b0, 1'b0));
            push("rtype ALUWB",   e(ST_AWB, 3'b000,   1'b0, 1'b0));
            drain(1'b1);
        end

        set_in(6'b000000, 6'b000000, 1'b0);
        fd("badfunct");
        push("badfunct EXECUTE", e(ST_EX, 3'b000, 1'b0, 1'b1));
        drain(1'b1);

        set_in(6'b100011, 6'b010101, 1'b0);
        fd("lw");
        push("lw MEMADR", e(ST_MA,  3'b000, 1'b0, 1'b0));
        push("lw MEMRD",  e(ST_MR,  3'b000, 1'b0, 1'b0));
        push("lw MEMWB",  e(ST_MWB, 3'b000, 1'b0, 1'b0));
        drain(1'b1);

        set_in(6'b101011, 6'b000000, 1'b1);
        fd("sw");
        push("sw MEMADR", e(ST_MA,  3'b000, 1'b0, 1'b0));
        push("sw MEMWR",  e(ST_MWR, 3'b000, 1'b0, 1'b0));
        drain(1'b1);

        set_in(6'b001000, 6'b111111, 1'b0);
        fd("addi");
        push("addi ADDIEXEC", e(ST_AE,   3'b000, 1'b0, 1'b0));
        push("addi ADDIWB",   e(ST_AIWB, 3'b000, 1'b0, 1'b0));
        drain(1'b1);

        set_in(6'b000100, 6'b000000, 1'b1);
        fd("beq taken");
        push("beq taken BRANCH", e(ST_BR, 3'b001, 1'b1, 1'b0));
        drain(1'b1);

        set_in(6'b000100, 6'b000000, 1'b0);
        fd("beq not taken");
        push("beq not taken BRANCH", e(ST_BR, 3'b001, 1'b0, 1'b0));
        drain(1'b1);

        set_in(6'b111111, 6'b100000, 1'b1);
        push("illop FETCH",  e(ST_F, 3'b000, 1'b1, 1'b0));
        push("illop DECODE", e(ST_D, 3'b000, 1'b0, 1'b1));
        drain(1'b1);

`ifdef BNE_EN
        set_in(6'b000101, 6'b000000, 1'b0);
        fd("bne taken");
        push("bne taken BRANCH", e(ST_BR, 3'b001, 1'b1, 1'b0));
        drain(1'b1);
        set_in(6'b000101, 6'b000000, 1'b1);
        fd("bne not taken");
        push("bne not taken BRANCH", e(ST_BR, 3'b001, 1'b0, 1'b0));
        drain(1'b1);
`else
        set_in(6'b000101, 6'b000000, 1'b0);
        push("bne FETCH",  e(ST_F, 3'b000, 1'b1, 1'b0));
        push("bne DECODE", e(ST_D, 3'b000, 1'b0, 1'b1));
        drain(1'b1);
`endif

        set_in(6'b101011, 6'b000000, 1'b0);
        fd("sw abort");
        push("sw abort MEMADR", e(ST_MA,  3'b000, 1'b0, 1'b0));
        push("sw abort MEMWR",  e(ST_MWR, 3'b000, 1'b0, 1'b0));
        drain(1'b0);
        reset = 1'b0;
        #1;
        check("reset during MEMWR", e_rst());
        @(posedge clk);
        #1;
        check("reset held", e_rst());
        reset = 1'b1;

        set_in(6'b100011, 6'b000000, 1'b0);
        fd("lw after reset");
        push("lw after reset MEMADR", e(ST_MA,  3'b000, 1'b0, 1'b0));
        push("lw after reset MEMRD",  e(ST_MR,  3'b000, 1'b0, 1'b0));
        push("lw after reset MEMWB",  e(ST_MWB, 3'b000, 1'b0, 1'b0));
        drain(1'b1);

        push("final FETCH", e(ST_F, 3'b000, 1'b1, 1'b0));
        drain(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
